caesar_sequencer: RTL

Controller that sequences the shared Caesar shift unit for the board-level cipher demo. On every prescaled tick it issues one symbol (0..25), the current key and the current direction to the external encrypt/decrypt datapath over a req/ack handshake. It captures the result and advances the symbol counter with wrap at 25. It also validates the switch key and produces the registered source, result and key values that the BCD/7-segment display chain consumes.

---
 rtl/caesar_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 27 ++
 rtl/caesar_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/caesar_pkg.sv
// Shared constants and state encoding for the Caesar cipher
// demo sequencer.
package caesar_pkg;

    localparam int ALPHA_LEN = 26;
    localparam int SYM_W     = 6;
    localparam int KEY_W     = 5;
    localparam int MAX_KEY   = 25;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        CAPTURE
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every
// TICK_DIV enabled clock cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/caesar_sequencer.sv
// Steps symbols 0..25 through the shared shift unit over req/ack
// and registers the source/result/key values for the display.
module caesar_sequencer
    import caesar_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic [KEY_W-1:0] SW,
    input  logic             ENCRYPT,
    input  logic             pause,
    output logic             shift_req,
    output logic [SYM_W-1:0] shift_sym,
    output logic [KEY_W-1:0] shift_key,
    output logic             shift_dir,
    input  logic             shift_ack,
    input  logic [SYM_W-1:0] shift_res,
    output logic [SYM_W-1:0] src_val,
    output logic [SYM_W-1:0] dst_val,
    output logic [KEY_W-1:0] key_val,
    output logic             valid,
    output logic             key_err,
    output logic             fault
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(ALPHA_LEN - 1);

    state_e             state;
    logic               tick;
    logic [KEY_W-1:0]   sw_s1, sw_s2;
    logic               enc_s1, enc_s2;
    logic [KEY_W-1:0]   eff_key;
    logic [KEY_W-1:0]   key_use;
    logic [SYM_W-1:0]   sym_cnt;
    logic [SYM_W-1:0]   res_q;
    logic [WAIT_W-1:0]  wait_cnt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .en       (1'b1),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            enc_s1  <= 1'b0;
            enc_s2  <= 1'b0;
            eff_key <= '0;
        end else begin
            sw_s1   <= SW;
            sw_s2   <= sw_s1;
            enc_s1  <= ENCRYPT;
            enc_s2  <= enc_s1;
            eff_key <= key_use;
        end
    end

    // An out-of-range key keeps the last legal one in force.
    assign key_err = (sw_s2 > KEY_W'(MAX_KEY));
    assign key_use = key_err ? eff_key : sw_s2;

    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_req <= 1'b0;
            shift_sym <= '0;
            shift_key <= '0;
            shift_dir <= 1'b1;
            src_val   <= '0;
            dst_val   <= '0;
            key_val   <= '0;
            valid     <= 1'b0;
            fault     <= 1'b0;
            sym_cnt   <= '0;
            res_q     <= '0;
            wait_cnt  <= '0;
        end else begin
            valid <= 1'b0;
            if (tick && !pause && state != IDLE) begin
                fault <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (tick && !pause) begin
                        shift_sym <= sym_cnt;
                        shift_key <= key_use;
                        shift_dir <= enc_s2;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    shift_req <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (shift_ack) begin
                        shift_req <= 1'b0;
                        res_q     <= shift_res;
                        state     <= CAPTURE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        shift_req <= 1'b0;
                        fault     <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    src_val <= shift_sym;
                    dst_val <= res_q;
                    key_val <= shift_key;
                    valid   <= 1'b1;
                    sym_cnt <= (sym_cnt == SYM_LAST) ? '0 : sym_cnt + 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
